// File: rtl/cam_fb_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : cam_fb_writer                                                    |
// | Purpose  : OV7670-style camera bus capture into an RGB565 frame-buffer RAM. |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+

module cam_fb_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic              enable,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wrclock,
    output logic [ADDR_W-1:0] wraddress,
    output logic [15:0]       wrdata,
    output logic              wren,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int CW    = $clog2(H_ACTIVE + 2);
    localparam int RW    = $clog2(V_ACTIVE + 2);

    // addr carries one spare bit so it can hold TOTAL even when TOTAL == 2**ADDR_W
    localparam logic [ADDR_W:0] ADDR_END = (ADDR_W + 1)'(TOTAL);
    localparam logic [CW-1:0]   COL_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0]   COL_SAT  = CW'(H_ACTIVE + 1);
    localparam logic [RW-1:0]   ROW_END  = RW'(V_ACTIVE);
    localparam logic [RW-1:0]   ROW_SAT  = RW'(V_ACTIVE + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    // Input bus layout: {pclk, vsync, href, data[7:0]}
    logic [10:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic              pclk3_q, pclk3_d, vsync3_q, vsync3_d;
    logic              pe;
    logic              byte_v_q, byte_v_d, line_end_q, line_end_d;
    logic              href_last_q, href_last_d;
    logic [7:0]        byte_q, byte_d;
    logic              vs_rise_q, vs_rise_d, vs_fall_q, vs_fall_d;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic              phase_q, phase_d;
    logic              err_q, err_d;
    logic [7:0]        hi_q, hi_d;

    logic [ADDR_W-1:0] wraddress_q, wraddress_d;
    logic [15:0]       wrdata_q, wrdata_d;
    logic              wren_q, wren_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        frame_count_q, frame_count_d;

    always_comb begin
        sync1_d     = {cam_pclk, cam_vsync, cam_href, cam_data};
        sync2_d     = sync1_q;
        pclk3_d     = sync2_q[10];
        vsync3_d    = sync2_q[9];
        pe          = sync2_q[10] & ~pclk3_q;
        byte_v_d    = pe & sync2_q[8];
        line_end_d  = pe & href_last_q & ~sync2_q[8];
        href_last_d = pe ? sync2_q[8] : href_last_q;
        byte_d      = pe ? sync2_q[7:0] : byte_q;
        vs_rise_d   = sync2_q[9] & ~vsync3_q;
        vs_fall_d   = ~sync2_q[9] & vsync3_q;
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        col_d         = col_q;
        row_d         = row_q;
        phase_d       = phase_q;
        err_d         = err_q;
        hi_d          = hi_q;
        wraddress_d   = wraddress_q;
        wrdata_d      = wrdata_q;
        wren_d        = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (vs_fall_q) begin
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    phase_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (vs_rise_q) begin
                    if (row_q == ROW_END && addr_q == ADDR_END && !err_q) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = enable ? S_ARM : S_IDLE;
                end else begin
                    if (vs_fall_q) begin
                        err_d = 1'b1;
                    end
                    if (byte_v_q) begin
                        if (!phase_q) begin
                            hi_d    = byte_q;
                            phase_d = 1'b1;
                        end else begin
                            // Pixels past the end of the buffer are flagged, never written
                            if (addr_q < ADDR_END) begin
                                wren_d      = 1'b1;
                                wraddress_d = addr_q[ADDR_W-1:0];
                                wrdata_d    = {hi_q, byte_q};
                                addr_d      = addr_q + 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                            if (col_q != COL_SAT) begin
                                col_d = col_q + 1'b1;
                            end
                            phase_d = 1'b0;
                        end
                    end else if (line_end_q) begin
                        if (col_q != COL_END || phase_q) begin
                            err_d = 1'b1;
                        end
                        if (row_q != ROW_SAT) begin
                            row_d = row_q + 1'b1;
                        end
                        col_d   = '0;
                        phase_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            pclk3_q       <= 1'b0;
            vsync3_q      <= 1'b0;
            byte_v_q      <= 1'b0;
            line_end_q    <= 1'b0;
            href_last_q   <= 1'b0;
            byte_q        <= '0;
            vs_rise_q     <= 1'b0;
            vs_fall_q     <= 1'b0;
            state_q       <= S_IDLE;
            addr_q        <= '0;
            col_q         <= '0;
            row_q         <= '0;
            phase_q       <= 1'b0;
            err_q         <= 1'b0;
            hi_q          <= '0;
            wraddress_q   <= '0;
            wrdata_q      <= '0;
            wren_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            pclk3_q       <= pclk3_d;
            vsync3_q      <= vsync3_d;
            byte_v_q      <= byte_v_d;
            line_end_q    <= line_end_d;
            href_last_q   <= href_last_d;
            byte_q        <= byte_d;
            vs_rise_q     <= vs_rise_d;
            vs_fall_q     <= vs_fall_d;
            state_q       <= state_d;
            addr_q        <= addr_d;
            col_q         <= col_d;
            row_q         <= row_d;
            phase_q       <= phase_d;
            err_q         <= err_d;
            hi_q          <= hi_d;
            wraddress_q   <= wraddress_d;
            wrdata_q      <= wrdata_d;
            wren_q        <= wren_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign wrclock     = CLOCK_50;
    assign wraddress   = wraddress_q;
    assign wrdata      = wrdata_q;
    assign wren        = wren_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_cam_fb_writer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_cam_fb_writer                                                 |
// | Purpose  : Self-checking bench for cam_fb_writer (H=4, V=2, pclk=clk/4).    |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+

module tb_cam_fb_writer;

    localparam int H = 4;
    localparam int V = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          cam_pclk = 1'b0;
    logic          cam_vsync = 1'b0;
    logic          cam_href = 1'b0;
    logic [7:0]    cam_data = 8'h00;
    logic          wrclock;
    logic [AW-1:0] wraddress;
    logic [15:0]   wrdata;
    logic          wren;
    logic          frame_done;
    logic          frame_err;
    logic [7:0]    frame_count;

    cam_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .CLOCK_50   (clk),
        .rst        (rst),
        .enable     (enable),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .wrclock    (wrclock),
        .wraddress  (wraddress),
        .wrdata     (wrdata),
        .wren       (wren),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed activity, sampled on the falling edge
    int          w_addr[$];
    logic [15:0] w_data[$];
    int          w_cyc[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          pulse_cyc = 0;
    int          viol_wren = 0;
    int          viol_both = 0;
    logic        wren_prev = 1'b0;

    always @(negedge clk) begin
        if (wren) begin
            w_addr.push_back(int'(wraddress));
            w_data.push_back(wrdata);
            w_cyc.push_back(cyc);
        end
        if (wren && wren_prev) viol_wren++;
        wren_prev = wren;
        if (frame_done) begin done_cnt++; pulse_cyc = cyc; end
        if (frame_err)  begin err_cnt++;  pulse_cyc = cyc; end
        if (frame_done && frame_err) viol_both++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame description and reference expectations
    int          line_len[$];
    logic [7:0]  cam_bytes[$];
    int          rise_q[$];
    int          exp_addr[$];
    logic [15:0] exp_data[$];
    bit          exp_good;
    int          fc_model = 0;
    int          last_samp = 0;
    int          vs_samp = 0;

    typedef struct {
        int nlines; int len0; int len1; int len2;
        int en; int drop; int exp_n; int exp_done; int exp_err;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One pclk period: bus set with pclk low for 2 clocks, then pclk high for 2
    task automatic pbyte(input logic h, input logic [7:0] d);
        cam_pclk = 1'b0;
        cam_href = h;
        cam_data = d;
        tick(); tick();
        cam_pclk = 1'b1;
        last_samp = cyc + 1;
        tick(); tick();
    endtask

    // Pixels are consecutive byte pairs within a line; leftovers are dropped at line end
    task automatic model_frame(input bit captured);
        int k = 0;
        int pix = 0;
        exp_addr.delete();
        exp_data.delete();
        exp_good = (line_len.size() == V);
        foreach (line_len[l]) begin
            if (line_len[l] != 2 * H) exp_good = 1'b0;
            for (int j = 0; j + 1 < line_len[l]; j += 2) begin
                if (pix < H * V) begin
                    exp_addr.push_back(pix);
                    exp_data.push_back({cam_bytes[k + j], cam_bytes[k + j + 1]});
                end else begin
                    exp_good = 1'b0;
                end
                pix++;
            end
            k += line_len[l];
        end
        if (!captured) begin
            exp_addr.delete();
            exp_data.delete();
        end
    endtask

    task automatic send_frame(input int drop_line);
        int k = 0;
        cam_vsync = 1'b1;
        repeat (8) tick();
        cam_vsync = 1'b0;
        repeat (2) pbyte(1'b0, 8'h00);
        foreach (line_len[l]) begin
            for (int j = 0; j < line_len[l]; j++) begin
                pbyte(1'b1, cam_bytes[k]);
                rise_q.push_back(last_samp);
                k++;
            end
            repeat (2) pbyte(1'b0, 8'h00);
            if (l == drop_line) enable = 1'b0;
        end
        cam_pclk = 1'b0;
        cam_vsync = 1'b1;
        vs_samp = cyc + 1;
        repeat (8) tick();
    endtask

    task automatic run_frame(input string name, input bit captured, input int drop_line,
                             input int exp_n, input int exp_done, input int exp_err);
        int n;
        w_addr.delete(); w_data.delete(); w_cyc.delete(); rise_q.delete();
        done_cnt = 0;
        err_cnt = 0;
        send_frame(drop_line);
        if (exp_done != 0) fc_model = (fc_model + 1) % 256;
        chk({name, "_nwrites"}, w_addr.size(), exp_n);
        n = (w_addr.size() < exp_addr.size()) ? w_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr%0d", name, i), w_addr[i], exp_addr[i]);
            chk($sformatf("%s_data%0d", name, i), 32'(w_data[i]), 32'(exp_data[i]));
        end
        chk({name, "_done"}, done_cnt, exp_done);
        chk({name, "_err"}, err_cnt, exp_err);
        chk({name, "_count"}, 32'(frame_count), fc_model);
        if (captured) chk({name, "_pulse_lat"}, pulse_cyc - vs_samp, 3);
        if (captured && exp_good && w_cyc.size() > 0 && rise_q.size() > 1)
            chk({name, "_wren_lat"}, w_cyc[0] - rise_q[1], 3);
    endtask

    task automatic counting_bytes();
        int total = 0;
        cam_bytes.delete();
        foreach (line_len[l]) total += line_len[l];
        for (int i = 0; i < total; i++) cam_bytes.push_back(8'(i));
    endtask

    initial begin
        tbl[0] = '{2, 8, 8, 0, 1, -1, 8, 1, 0};   // good frame
        tbl[1] = '{2, 6, 8, 0, 1, -1, 7, 0, 1};   // short first line
        tbl[2] = '{3, 8, 8, 8, 1, -1, 8, 0, 1};   // too many lines
        tbl[3] = '{2, 7, 8, 0, 1, -1, 7, 0, 1};   // odd byte count
        tbl[4] = '{2, 10, 8, 0, 1, -1, 8, 0, 1};  // wide line overruns buffer
        tbl[5] = '{2, 8, 8, 0, 1, 0, 8, 1, 0};    // enable dropped mid-frame
        tbl[6] = '{2, 8, 8, 0, 0, -1, 0, 0, 0};   // disabled: nothing captured
        tbl[7] = '{2, 8, 8, 0, 1, -1, 8, 1, 0};   // re-enabled

        repeat (3) tick();
        chk("rst_wraddress", 32'(wraddress), 0);
        chk("rst_wrdata", 32'(wrdata), 0);
        chk("rst_wren", 32'(wren), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_frame_count", 32'(frame_count), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            line_len.delete();
            line_len.push_back(tbl[i].len0);
            if (tbl[i].nlines > 1) line_len.push_back(tbl[i].len1);
            if (tbl[i].nlines > 2) line_len.push_back(tbl[i].len2);
            counting_bytes();
            enable = (tbl[i].en != 0);
            tick();
            model_frame(tbl[i].en != 0);
            run_frame($sformatf("vec%0d", i), tbl[i].en != 0, tbl[i].drop,
                      tbl[i].exp_n, tbl[i].exp_done, tbl[i].exp_err);
        end

        // Reset in the middle of a frame, after the third pixel write
        w_addr.delete(); w_data.delete(); w_cyc.delete();
        done_cnt = 0;
        err_cnt = 0;
        cam_vsync = 1'b1;
        repeat (8) tick();
        cam_vsync = 1'b0;
        repeat (2) pbyte(1'b0, 8'h00);
        for (int j = 0; j < 6; j++) pbyte(1'b1, 8'(j));
        cam_pclk = 1'b0;
        for (int i = 0; i < 20 && w_addr.size() < 3; i++) tick();
        chk("midrst_writes_before", w_addr.size(), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wraddress", 32'(wraddress), 0);
        chk("midrst_wrdata", 32'(wrdata), 0);
        chk("midrst_wren", 32'(wren), 0);
        chk("midrst_frame_count", 32'(frame_count), 0);
        cam_href = 1'b0;
        cam_vsync = 1'b1;
        repeat (12) tick();
        chk("midrst_no_pulse", done_cnt + err_cnt, 0);
        chk("midrst_no_more_writes", w_addr.size(), 3);
        fc_model = 0;
        line_len.delete();
        line_len.push_back(2 * H);
        line_len.push_back(2 * H);
        counting_bytes();
        model_frame(1'b1);
        run_frame("after_rst", 1'b1, -1, 8, 1, 0);

        // Randomized frames against the reference model
        for (int f = 0; f < 20; f++) begin
            int nl;
            int total = 0;
            nl = int'($urandom_range(1, 3));
            line_len.delete();
            cam_bytes.delete();
            for (int l = 0; l < nl; l++) begin
                int len;
                len = ($urandom_range(0, 1) == 1) ? 2 * H : int'($urandom_range(2, 10));
                line_len.push_back(len);
                total += len;
            end
            for (int i = 0; i < total; i++) cam_bytes.push_back(8'($urandom));
            model_frame(1'b1);
            run_frame($sformatf("rnd%0d", f), 1'b1, -1, exp_addr.size(),
                      int'(exp_good), int'(!exp_good));
        end

        // frame_count wraps after 256 good frames
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        line_len.delete();
        line_len.push_back(2 * H);
        line_len.push_back(2 * H);
        counting_bytes();
        done_cnt = 0;
        err_cnt = 0;
        for (int f = 0; f < 256; f++) begin
            w_addr.delete(); w_data.delete(); w_cyc.delete(); rise_q.delete();
            send_frame(-1);
            if (f == 254) chk("wrap_count_255", 32'(frame_count), 255);
        end
        chk("wrap_count_0", 32'(frame_count), 0);
        chk("wrap_done_total", done_cnt, 256);
        chk("wrap_err_total", err_cnt, 0);

        chk("wren_single_cycle", viol_wren, 0);
        chk("pulses_exclusive", viol_both, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
